// File: rtl/ysyx_22050133_fetch_queue.sv
// Fetch unit: one outstanding memory read feeding a DEPTH-entry instruction queue.
// Optional: define YSYX_22050133_FQ_BYPASS_EN to forward a response past an empty queue.
module ysyx_22050133_fetch_queue #(
    parameter int unsigned        ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(64'h8000_0000),
    parameter int unsigned        DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [63:0]       rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              kill;
    logic              kill_nxt;
    logic              live;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [31:0]       q_inst [DEPTH];
    logic [31:0]       rsp_word;
    logic              q_valid;
    logic              take;
    logic              byp;
    logic              push;
    logic              pop;

    // Response word select, accept decision and queue push/pop control
    always_comb begin
        rsp_word = pc[2] ? rsp_data[63:32] : rsp_data[31:0];
        q_valid  = (count != '0);
        take     = (state == WAIT) && rsp_valid && !redirect_valid;
`ifdef YSYX_22050133_FQ_BYPASS_EN
        byp      = take && !q_valid;
`else
        byp      = 1'b0;
`endif
        pop      = q_valid && inst_ready && !redirect_valid;
        push     = take && !(byp && inst_ready);
        count_nxt = count;
        if (redirect_valid)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + CW'(1);
        else if (!push && pop)
            count_nxt = count - CW'(1);
    end

    // Fetch FSM next state, fetch PC and kill flag
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        if (redirect_valid)
            pc_nxt = redirect_pc;
        unique case (state)
            IDLE: begin
                if (live && !redirect_valid && count < FULL)
                    state_nxt = REQ;
            end
            REQ: begin
                if (req_ready) begin
                    state_nxt = (kill || redirect_valid) ? DROP : WAIT;
                    kill_nxt  = 1'b0;
                end else if (redirect_valid) begin
                    kill_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_nxt = rsp_valid ? IDLE : DROP;
                end else if (rsp_valid) begin
                    pc_nxt    = pc + ADDR_W'(4);
                    state_nxt = (count_nxt < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (rsp_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers; one settling cycle after reset before the first fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            kill   <= 1'b0;
            live   <= 1'b0;
            count  <= '0;
            wptr   <= '0;
            rptr   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            live  <= 1'b1;
            count <= count_nxt;
            if (state != REQ)
                addr_q <= pc_nxt;
            if (redirect_valid) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push)
                    wptr <= wptr + PW'(1);
                if (pop)
                    rptr <= rptr + PW'(1);
            end
        end
    end

    // Queue storage; contents only matter while counted valid
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wptr]   <= pc;
            q_inst[wptr] <= rsp_word;
        end
    end

    // Output drive; zero when nothing valid
    always_comb begin
        req_valid  = (state == REQ);
        req_addr   = addr_q;
        inst_valid = q_valid || byp;
        inst       = '0;
        inst_pc    = '0;
        if (byp) begin
            inst    = rsp_word;
            inst_pc = pc;
        end else if (q_valid) begin
            inst    = q_inst[rptr];
            inst_pc = q_pc[rptr];
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_fetch_queue.sv
// Bench for ysyx_22050133_fetch_queue: transaction-level model plus directed cases.
// Memory word at address a holds a[31:0] ^ 32'h1357_9BDF.
module tb_ysyx_22050133_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    always #5 clk = ~clk;

    ysyx_22050133_fetch_queue #(
        .ADDR_W(64), .RESET_PC(RPC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    bit          m_pend, m_pend_dead, m_out, m_out_dead;
    logic [63:0] m_pend_addr;

    int          lat, rsp_due;
    logic [63:0] rsp_addr;
    logic [63:0] hs_log[$];
    logic [63:0] pop_pc[$];
    logic [31:0] pop_ins[$];
    int          cyc, first_rsp, first_iv;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic clr_logs();
        hs_log.delete();
        pop_pc.delete();
        pop_ins.delete();
        cyc = 0;
        first_rsp = -1;
        first_iv = -1;
    endtask

    // One clock: respond, compare against the model, advance the model.
    // Entered and left just after a falling edge.
    task automatic tick();
        bit   hs, byp, popq;
        ent_t e;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        if (rsp_due > 0) begin
            rsp_due--;
            if (rsp_due == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = {memf({rsp_addr[63:3], 3'b100}),
                             memf({rsp_addr[63:3], 3'b000})};
            end
        end
        #1;
        if (rst_n) begin
            byp = 1'b0;
`ifdef YSYX_22050133_FQ_BYPASS_EN
            byp = rsp_valid && m_out && !m_out_dead &&
                  !redirect_valid && mq.size() == 0;
`endif
            chk("inst_valid", inst_valid, (mq.size() != 0) || byp);
            if (mq.size() != 0) begin
                chk("inst_pc", inst_pc, mq[0].pc);
                chk("inst", inst, mq[0].ins);
            end else if (byp) begin
                chk("inst_pc_byp", inst_pc, m_pc);
                chk("inst_byp", inst, memf(m_pc));
            end
            if (inst_valid && inst_ready) begin
                pop_pc.push_back(inst_pc);
                pop_ins.push_back(inst);
            end
            if (rsp_valid && first_rsp < 0) first_rsp = cyc;
            if (inst_valid && first_iv < 0) first_iv = cyc;
            if (m_pend) begin
                chk("req_valid_hold", req_valid, 1);
                chk("req_addr_hold", req_addr, m_pend_addr);
                if (!req_valid) m_pend = 0;
            end else if (req_valid) begin
                chk("req_addr_new", req_addr, m_pc);
                chk("req_single", m_out, 0);
                chk("req_room", mq.size() < DEPTH, 1);
                m_pend = 1;
                m_pend_addr = req_addr;
                m_pend_dead = 0;
            end
            hs = req_valid && req_ready;
            if (hs) hs_log.push_back(req_addr);
            popq = inst_ready && mq.size() != 0;
            if (redirect_valid) begin
                mq.delete();
                m_pc = redirect_pc;
                if (m_pend) m_pend_dead = 1;
                if (m_out) m_out_dead = 1;
            end else if (popq) begin
                void'(mq.pop_front());
            end
            if (rsp_valid && m_out) begin
                if (!m_out_dead && !redirect_valid) begin
                    if (!(byp && inst_ready)) begin
                        e.pc = m_pc;
                        e.ins = memf(m_pc);
                        mq.push_back(e);
                    end
                    m_pc = m_pc + 64'd4;
                end
                m_out = 0;
            end
            if (hs) begin
                m_pend = 0;
                m_out = 1;
                m_out_dead = m_pend_dead;
                rsp_due = lat;
                rsp_addr = req_addr;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit keep_mem, input int n);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        req_ready = 1'b0;
        inst_ready = 1'b0;
        mq.delete();
        m_pc = RPC;
        m_pend = 0;
        m_pend_dead = 0;
        m_out = 0;
        m_out_dead = 0;
        if (!keep_mem) rsp_due = 0;
        repeat (n) tick();
        rst_n = 1'b1;
        clr_logs();
    endtask

    task automatic wait_hs(input int n, input string nm);
        for (int i = 0; i < 60 && hs_log.size() < n; i++) tick();
        chk(nm, hs_log.size(), n);
    endtask

    task automatic wait_pop(input string nm);
        for (int i = 0; i < 60 && pop_pc.size() == 0; i++) tick();
        chk(nm, pop_pc.size(), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        req_ready = 1'b0;
        inst_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        lat = 1;
        rsp_due = 0;
        clr_logs();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_req_addr", req_addr, RPC);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        @(negedge clk);

        // Streaming fetch, one-cycle memory
        do_reset(0, 2);
        req_ready = 1; inst_ready = 1; lat = 1;
        chk("rel_req_valid0", req_valid, 0);
        tick();
        chk("rel_req_valid1", req_valid, 0);
        tick();
        chk("rel_req_valid2", req_valid, 1);
        chk("rel_req_addr", req_addr, RPC);
        repeat (10) tick();
        chk("seq_addr0", hs_log[0], 64'h8000_0000);
        chk("seq_addr1", hs_log[1], 64'h8000_0004);
        chk("seq_addr2", hs_log[2], 64'h8000_0008);
        chk("seq_inst0", pop_ins[0], 32'h9357_9BDF);
        chk("seq_inst1", pop_ins[1], 32'h9357_9BDB);
`ifdef YSYX_22050133_FQ_BYPASS_EN
        chk("rsp_to_valid", first_iv - first_rsp, 0);
`else
        chk("rsp_to_valid", first_iv - first_rsp, 1);
`endif

        // Queue fills while decoder stalls
        do_reset(0, 2);
        req_ready = 1; inst_ready = 0; lat = 1;
        repeat (20) tick();
        chk("full_pushes", hs_log.size(), 4);
        chk("full_req_valid", req_valid, 0);
        chk("full_inst_pc", inst_pc, RPC);
        inst_ready = 1;
        wait_hs(5, "resume_hs");
        chk("resume_addr", hs_log[4], 64'h8000_0010);

        // Redirect during WAIT, response two cycles later
        do_reset(0, 2);
        req_ready = 1; inst_ready = 1; lat = 3;
        wait_hs(1, "w_hs");
        redirect_valid = 1; redirect_pc = 64'h8000_1000;
        tick();
        redirect_valid = 0;
        tick();
        tick();
        chk("w_drop_empty", inst_valid, 0);
        wait_hs(2, "w_hs2");
        chk("w_next_addr", hs_log[1], 64'h8000_1000);

        // Redirect while request is stalled
        do_reset(0, 2);
        req_ready = 0; inst_ready = 1; lat = 1;
        for (int i = 0; i < 10 && !req_valid; i++) tick();
        chk("k_req_up", req_valid, 1);
        redirect_valid = 1; redirect_pc = 64'h8000_2000;
        tick();
        redirect_valid = 0;
        tick();
        tick();
        chk("k_addr_stable", req_addr, RPC);
        req_ready = 1;
        tick();
        chk("k_drop_no_req", req_valid, 0);
        wait_pop("k_pop");
        chk("k_first_pc", pop_pc[0], 64'h8000_2000);

        // Redirect coincident with response, queue full with in-flight entry
        do_reset(0, 2);
        req_ready = 1; inst_ready = 0; lat = 2;
        wait_hs(4, "f_hs");
        tick();
        chk("f_valid_before", inst_valid, 1);
        redirect_valid = 1; redirect_pc = 64'h8000_3000; inst_ready = 1;
        tick();
        redirect_valid = 0; inst_ready = 0;
        chk("f_count0", inst_valid, 0);
        inst_ready = 1;
        wait_hs(5, "f_hs5");
        chk("f_next_addr", hs_log[4], 64'h8000_3000);

        // Reset mid-request, stale response lands in IDLE
        do_reset(0, 2);
        req_ready = 1; inst_ready = 1; lat = 3;
        wait_hs(1, "r_hs");
        do_reset(1, 1);
        req_ready = 1; inst_ready = 1;
        tick();
        tick();
        chk("r_late_ignored", inst_valid, 0);
        chk("r_req_valid", req_valid, 1);
        chk("r_req_addr", req_addr, RPC);
        wait_pop("r_pop");
        chk("r_first_pc", pop_pc[0], RPC);
        chk("r_first_inst", pop_ins[0], 32'h9357_9BDF);

        // Mixed traffic with periodic redirects, model-checked
        do_reset(0, 2);
        for (int i = 0; i < 300; i++) begin
            lat = 1 + i / 100;
            req_ready = (i % 3) != 0;
            inst_ready = (i % 5) < 3;
            redirect_valid = (i % 37) == 36;
            redirect_pc = 64'h8000_4000 + 64'(i * 4);
            tick();
        end
        redirect_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
